// File: rtl/pc_unit_pkg.sv
// Shared definitions for the fetch-stage program counter: next-PC select
// encodings, control FSM states and the default reset/fetch base address.
package pc_unit_pkg;

    // Also the base of the instruction-memory address translation.
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'd0,
        NPC_BR  = 2'd1,
        NPC_J   = 2'd2,
        NPC_JR  = 2'd3
    } npc_sel_e;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

endpackage

// File: rtl/pc_unit_npc_calc.sv
// Combinational next-PC generator: selects the candidate target and checks
// that it is word aligned and inside the instruction-memory window.
import pc_unit_pkg::*;

module npc_calc #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IM_DEPTH = 1024
) (
    input  logic [31:0] pc,
    input  logic [1:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] npc,
    output logic        target_ok
);

    // Window end is held in 33 bits so a window touching 2^32 cannot wrap.
    localparam logic [32:0] WIN_BASE = {1'b0, RESET_PC};
    localparam logic [32:0] WIN_END  = WIN_BASE + (33'(IM_DEPTH) << 2);

    logic [31:0] br_offset;
    logic [31:0] br_target;
    logic [31:0] jmp_target;

    assign pc_plus4   = pc + 32'd4;
    assign br_offset  = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_target  = pc_plus4 + br_offset;
    assign jmp_target = {pc_plus4[31:28], instr_index, 2'b00};

    always_comb begin
        npc = pc_plus4;
        case (npc_sel)
            NPC_SEQ: npc = pc_plus4;
            NPC_BR:  npc = branch_taken ? br_target : pc_plus4;
            NPC_J:   npc = jmp_target;
            NPC_JR:  npc = rs_data;
            default: npc = pc_plus4;
        endcase
    end

    assign target_ok = (npc[1:0] == 2'b00)
                    && ({1'b0, npc} >= WIN_BASE)
                    && ({1'b0, npc} <  WIN_END);

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: holds the PC, advances it from the decoded
// control, honours stalls and halts permanently on a rejected target.
import pc_unit_pkg::*;

module pc_unit #(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int unsigned IM_DEPTH = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  npc_sel,
    input  logic        branch_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] instr_index,
    input  logic [31:0] rs_data,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic [31:0] fault_addr,
    output logic [31:0] fetch_count
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] fault_q, fault_d;
    logic [31:0] count_q, count_d;

    logic [31:0] npc;
    logic        target_ok;
    logic        advance;

    npc_calc #(
        .RESET_PC (RESET_PC),
        .IM_DEPTH (IM_DEPTH)
    ) u_npc_calc (
        .pc           (pc_q),
        .npc_sel      (npc_sel),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .instr_index  (instr_index),
        .rs_data      (rs_data),
        .pc_plus4     (pc_plus4),
        .npc          (npc),
        .target_ok    (target_ok)
    );

    // A stalled cycle never evaluates the target, so it can neither move nor halt.
    assign advance = (state_q == RUN) && !stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            fault_q <= 32'd0;
            count_q <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (advance && !target_ok) begin
            state_d = HALT;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        count_d = count_q;
        if (advance) begin
            if (target_ok) begin
                pc_d    = npc;
                count_d = count_q + 32'd1;
            end else begin
                fault_d = npc;
            end
        end
    end

    assign pc          = pc_q;
    assign halted      = (state_q == HALT);
    assign fault_addr  = fault_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal
// expectations, then randomized control checked against a behavioural model.
module tb_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int unsigned DEPTH  = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  npc_sel;
    logic        branch_taken;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_data;
    logic        stall;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        halted;
    logic [31:0] fault_addr;
    logic [31:0] fetch_count;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic        m_halt;
    logic [31:0] m_fault;
    logic [31:0] m_count;

    pc_unit #(
        .RESET_PC (RST_PC),
        .IM_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .npc_sel      (npc_sel),
        .branch_taken (branch_taken),
        .imm16        (imm16),
        .instr_index  (instr_index),
        .rs_data      (rs_data),
        .stall        (stall),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .halted       (halted),
        .fault_addr   (fault_addr),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Target the current inputs would request, from the architectural rules.
    function automatic logic [31:0] model_target(input logic [31:0] cur);
        int          off;
        logic [31:0] seq;
        seq = cur + 32'd4;
        off = int'($signed(imm16)) * 4;
        case (npc_sel)
            2'd0: return seq;
            2'd1: return branch_taken ? seq + 32'(off) : seq;
            2'd2: return (seq & 32'hF000_0000) | (32'(instr_index) * 32'd4);
            default: return rs_data;
        endcase
    endfunction

    function automatic bit model_valid(input logic [31:0] a);
        longint unsigned n = longint'(a);
        return (n % 4 == 0) && (n >= longint'(RST_PC))
            && (n < longint'(RST_PC) + 4 * longint'(DEPTH));
    endfunction

    task automatic model_reset();
        m_pc    = RST_PC;
        m_halt  = 1'b0;
        m_fault = 32'd0;
        m_count = 32'd0;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("pc", pc, m_pc);
            chk("pc_plus4", pc_plus4, m_pc + 32'd4);
            chk("halted", {31'd0, halted}, {31'd0, m_halt});
            chk("fault_addr", fault_addr, m_fault);
            chk("fetch_count", fetch_count, m_count);
        end
    end

    // Apply one cycle of control (called at posedge+1), then advance model and DUT.
    task automatic cycle(input logic [1:0] sel, input logic tk, input logic [15:0] imm,
                         input logic [25:0] idx, input logic [31:0] rs, input logic st);
        logic [31:0] t;
        npc_sel = sel; branch_taken = tk; imm16 = imm; instr_index = idx;
        rs_data = rs; stall = st;
        t = model_target(m_pc);
        @(posedge clk);
        #1;
        if (!m_halt && !st) begin
            if (model_valid(t)) begin
                m_pc    = t;
                m_count = m_count + 32'd1;
            end else begin
                m_fault = t;
                m_halt  = 1'b1;
            end
        end
        $display("cyc sel=%0d tk=%0b imm=%04h idx=%07h rs=%08h st=%0b -> pc=%08h halted=%0b fault=%08h cnt=%0d",
                 sel, tk, imm, idx, rs, st, pc, halted, fault_addr, fetch_count);
    endtask

    // Asynchronous assertion mid-cycle; outputs must clear before any edge.
    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        #1;
        chk("rst_pc", pc, RST_PC);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_fault", fault_addr, 32'd0);
        chk("rst_count", fetch_count, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        npc_sel = 2'd0; branch_taken = 1'b0; imm16 = 16'd0;
        instr_index = 26'd0; rs_data = 32'd0; stall = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_en = 1'b1;
        chk("init_pc", pc, 32'h3000);
        chk("init_count", fetch_count, 32'd0);

        // Sequential fetch
        cycle(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        cycle(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("seq_pc2", pc, 32'h3008);
        cycle(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("seq_pc3", pc, 32'h300C);
        chk("seq_count", fetch_count, 32'd3);

        // Branch self-loop, not-taken, jump, jr halts
        do_reset();
        cycle(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        cycle(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        cycle(2'd1, 1'b1, 16'hFFFF, 26'h0, 32'h0, 1'b0);
        chk("br_taken_pc", pc, 32'h3008);
        cycle(2'd1, 1'b0, 16'hFFFF, 26'h0, 32'h0, 1'b0);
        chk("br_nt_pc", pc, 32'h300C);
        cycle(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("j_pc_plus4", pc_plus4, 32'h3014);
        cycle(2'd2, 1'b0, 16'h0, 26'h0000C40, 32'h0, 1'b0);
        chk("j_pc", pc, 32'h3100);
        chk("j_count", fetch_count, 32'd6);
        cycle(2'd3, 1'b0, 16'h0, 26'h0, 32'h3002, 1'b0);
        chk("jr_mis_halted", {31'd0, halted}, 32'd1);
        chk("jr_mis_fault", fault_addr, 32'h3002);
        chk("jr_mis_pc", pc, 32'h3100);
        cycle(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        cycle(2'd3, 1'b0, 16'h0, 26'h0, 32'h3400, 1'b0);
        chk("halt_hold_pc", pc, 32'h3100);
        chk("halt_hold_count", fetch_count, 32'd6);

        // Reset out of HALT, fetch resumes
        do_reset();
        cycle(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("resume_pc", pc, 32'h3004);
        cycle(2'd3, 1'b0, 16'h0, 26'h0, 32'h4000, 1'b0);
        chk("win_end_fault", fault_addr, 32'h4000);
        chk("win_end_halted", {31'd0, halted}, 32'd1);

        // Stall masks an invalid target
        do_reset();
        cycle(2'd3, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
        cycle(2'd3, 1'b0, 16'h0, 26'h0, 32'h0, 1'b1);
        chk("stall_pc", pc, 32'h3000);
        chk("stall_halted", {31'd0, halted}, 32'd0);
        cycle(2'd3, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("unstall_halted", {31'd0, halted}, 32'd1);
        chk("unstall_fault", fault_addr, 32'h0);

        // Sequential fetch off the last word
        do_reset();
        cycle(2'd3, 1'b0, 16'h0, 26'h0, 32'h3FFC, 1'b0);
        chk("last_word_pc", pc, 32'h3FFC);
        cycle(2'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
        chk("last_word_fault", fault_addr, 32'h4000);
        chk("last_word_pc_held", pc, 32'h3FFC);

        // Randomized control against the model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic [1:0]  sel;
            logic [15:0] imm;
            logic [25:0] idx;
            logic [31:0] rs;
            if (m_halt && ($urandom_range(0, 3) == 0)) begin
                do_reset();
            end
            sel = 2'($urandom_range(0, 3));
            imm = 16'($urandom_range(0, 31)) - 16'd16;
            idx = 26'h0000C00 + 26'($urandom_range(0, 1027));
            rs  = RST_PC + 32'd4 * 32'($urandom_range(0, 1030));
            if ($urandom_range(0, 7) == 0) rs = rs + 32'd2;
            cycle(sel, 1'($urandom_range(0, 1)), imm, idx, rs, ($urandom_range(0, 4) == 0));
        end

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
